// File: rtl/wrr_lock_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin lock arbiter.
// The state enum, the default weight and a reference round-robin pick function live here.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int DEFAULT_WEIGHT = 1;
    localparam int MAX_N          = 16;

    // Returns the first set index scanning ptr, ptr+1, ... with wrap modulo n, or -1 if none.
    function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
        int pick;
        int idx;
        pick = -1;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (pick < 0 && req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wrr_lock_arbiter_rr_find_first.sv
// Combinational round-robin search: rotate the request vector so ptr lands at bit 0,
// priority-encode the lowest set bit, then map the offset back to an absolute index.
module rr_find_first #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [2*N-1:0] w_double;
    logic [2*N-1:0] w_shift;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    int             w_sum;

    assign w_double = {i_req, i_req};
    assign w_shift  = w_double >> i_ptr;
    assign w_rot    = w_shift[N-1:0];

    always_comb begin
        o_found = 1'b0;
        w_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_found = 1'b1;
                w_off   = IW'(i);
            end
        end
    end

    // Unrotate with an explicit modulo so non-power-of-two N still wraps correctly.
    always_comb begin
        w_sum = int'(i_ptr) + int'(w_off);
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        o_idx = IW'(w_sum);
    end

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter that locks each grant for a whole transaction.
// Credits reload lazily from weight only when no requester has credit left.
module wrr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    input  logic          last,
    input  logic [N*CW-1:0] weight,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id
);

    arb_state_e    r_state;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_credit [N];
    logic [N-1:0]  r_grant;
    logic          r_grantValid;
    logic [IW-1:0] r_grantId;

    logic [N-1:0]  w_elig;
    logic [N-1:0]  w_cand;
    logic          w_arbitrate;
    logic          w_reload;
    logic [IW-1:0] w_winIdx;
    logic          w_found;
    logic          w_release;
    logic [CW-1:0] w_ownerCred;
    logic [CW-1:0] w_credDec;
    logic [IW-1:0] w_nextPtr;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N; i++) begin
            w_elig[i] = req[i] && (r_credit[i] != '0);
        end
    end

    assign w_arbitrate = (r_state == IDLE) && en && (|req);
    assign w_reload    = w_arbitrate && (w_elig == '0);
    assign w_cand      = w_reload ? req : w_elig;

    rr_find_first #(.N(N)) u_findFirst (
        .i_req   (w_cand),
        .i_ptr   (r_ptr),
        .o_idx   (w_winIdx),
        .o_found (w_found)
    );

    // Releasing owner decides where the pointer goes: stay while it still has credit.
    assign w_release   = (r_state == LOCK) && (last || !req[r_grantId]);
    assign w_ownerCred = r_credit[r_grantId];
    assign w_credDec   = (w_ownerCred == '0) ? '0 : w_ownerCred - CW'(1);
    assign w_nextPtr   = (int'(r_grantId) == N - 1) ? '0 : r_grantId + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_grantValid <= 1'b0;
            r_grantId    <= '0;
            for (int i = 0; i < N; i++) begin
                r_credit[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arbitrate && w_found) begin
                        r_grant      <= N'(1) << w_winIdx;
                        r_grantValid <= 1'b1;
                        r_grantId    <= w_winIdx;
                        r_state      <= LOCK;
                        if (w_reload) begin
                            for (int i = 0; i < N; i++) begin
                                r_credit[i] <= (weight[i*CW +: CW] == '0) ?
                                               CW'(DEFAULT_WEIGHT) : weight[i*CW +: CW];
                            end
                        end
                    end
                end
                LOCK: begin
                    if (w_release) begin
                        r_credit[r_grantId] <= w_credDec;
                        r_ptr        <= (w_credDec == '0) ? w_nextPtr : r_grantId;
                        r_grant      <= '0;
                        r_grantValid <= 1'b0;
                        r_grantId    <= '0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grantValid;
    assign grant_id    = r_grantId;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Scoreboard bench for wrr_lock_arbiter: a behavioural model predicts the grant bus for
// every cycle, and a negedge monitor compares the DUT against those predictions.
module tb_wrr_lock_arbiter;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int IW = $clog2(N);

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic          last;
    logic [N*CW-1:0] weight;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;

    typedef struct {
        int           cyc;
        logic [N-1:0] grant;
    } exp_t;

    exp_t expQ[$];
    int   negCount = 0;
    int   checks   = 0;
    int   errors   = 0;

    int   mCred[N];
    int   mPtr;
    bit   mBusy;
    int   mOwner;
    int   mHeld;

    wrr_lock_arbiter #(.N(N), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .last        (last),
        .weight      (weight),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare the whole grant bus against an expected one-hot (or zero) grant.
    task automatic checkOutput(input string name, input logic [N-1:0] expGrant);
        logic          expValid;
        logic [IW-1:0] expId;
        expValid = |expGrant;
        expId    = '0;
        for (int i = 0; i < N; i++) begin
            if (expGrant[i]) expId = IW'(i);
        end
        checks++;
        if (grant !== expGrant || grant_valid !== expValid || grant_id !== expId) begin
            errors++;
            $display("[TB] FAIL %s t=%0t: got grant=%b valid=%b id=%0d, want grant=%b valid=%b id=%0d",
                     name, $time, grant, grant_valid, grant_id, expGrant, expValid, expId);
        end
    endtask

    // Monitor: at every falling edge pop the prediction scheduled for this cycle and check it.
    always @(negedge clk) begin
        exp_t e;
        negCount++;
        if (expQ.size() > 0 && expQ[0].cyc < negCount) begin
            e = expQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL schedule: got stale entry for cycle %0d, want cycle %0d", e.cyc, negCount);
        end
        if (expQ.size() > 0 && expQ[0].cyc == negCount) begin
            e = expQ.pop_front();
            checkOutput("grantBus", e.grant);
        end
    end

    // Reference model: one call per clock, using the inputs that the next rising edge will sample.
    task automatic modelStep();
        logic [N-1:0] elig;
        logic [N-1:0] expGrant;
        int           win;
        if (!mBusy) begin
            if (en && req != '0) begin
                elig = '0;
                for (int i = 0; i < N; i++) begin
                    if (req[i] && mCred[i] > 0) elig[i] = 1'b1;
                end
                if (elig == '0) begin
                    for (int i = 0; i < N; i++) begin
                        mCred[i] = int'(weight[i*CW +: CW]);
                        if (mCred[i] == 0) mCred[i] = 1;
                    end
                    elig = req;
                end
                win = -1;
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && elig[(mPtr + k) % N]) win = (mPtr + k) % N;
                end
                mBusy  = 1'b1;
                mOwner = win;
                mHeld  = 1;
            end
        end else if (last || !req[mOwner]) begin
            if (mCred[mOwner] > 0) mCred[mOwner]--;
            mPtr  = (mCred[mOwner] == 0) ? (mOwner + 1) % N : mOwner;
            mBusy = 1'b0;
        end else begin
            mHeld++;
        end
        expGrant = '0;
        if (mBusy) expGrant[mOwner] = 1'b1;
        expQ.push_back('{cyc: negCount + 1, grant: expGrant});
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) mCred[i] = 0;
        mPtr   = 0;
        mBusy  = 1'b0;
        mOwner = 0;
        mHeld  = 0;
        expQ.delete();
    endtask

    task automatic applyStimulus(input logic e, input logic [N-1:0] r, input logic l);
        @(negedge clk);
        #1;
        en   = e;
        req  = r;
        last = l;
        modelStep();
    endtask

    task automatic resetDut();
        @(negedge clk);
        #1;
        rst  = 1'b1;
        en   = 1'b0;
        req  = '0;
        last = 1'b0;
        modelReset();
        #1;
        checkOutput("resetHeld", '0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Main stimulus sequence: directed scenarios followed by a randomized soak.
    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        req    = '0;
        last   = 1'b0;
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        modelReset();
        #2;
        checkOutput("powerOnReset", '0);
        #10;
        rst = 1'b0;

        // Single requester, last in the third grant cycle.
        for (int c = 0; c < 14; c++) applyStimulus(1'b1, 4'b0100, mBusy && mHeld == 3);

        // Round robin with weights all 1 and single-beat transactions.
        resetDut();
        for (int c = 0; c < 20; c++) applyStimulus(1'b1, 4'b1111, 1'b1);

        // Weighted share: requester 0 gets three transactions per one of requester 1.
        resetDut();
        weight = {4'd1, 4'd1, 4'd1, 4'd3};
        for (int c = 0; c < 24; c++) applyStimulus(1'b1, 4'b0011, 1'b1);

        // Owner 2 drops its request mid-transaction while 1 and 3 wait.
        resetDut();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        applyStimulus(1'b1, 4'b0100, 1'b0);
        applyStimulus(1'b1, 4'b1110, 1'b0);
        applyStimulus(1'b1, 4'b1110, 1'b0);
        applyStimulus(1'b1, 4'b1010, 1'b0);
        for (int c = 0; c < 8; c++) applyStimulus(1'b1, 4'b1010, 1'b1);

        // en low during a transaction lets it finish but blocks the next grant.
        resetDut();
        applyStimulus(1'b1, 4'b0011, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 4'b0011, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b1, 4'b0011, 1'b1);

        // Asynchronous reset between edges while a grant is locked.
        resetDut();
        applyStimulus(1'b1, 4'b0100, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b0);
        #2;
        rst  = 1'b1;
        en   = 1'b0;
        req  = '0;
        modelReset();
        #1;
        checkOutput("asyncResetMidLock", '0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) applyStimulus(1'b1, 4'b1010, 1'b1);

        // Randomized soak with occasional weight changes.
        resetDut();
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) weight = 16'($urandom);
            applyStimulus($urandom_range(0, 99) < 85,
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 99) < 40);
        end

        applyStimulus(1'b0, 4'b0000, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d unchecked predictions, want 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
